ex_mem_pipe: RTL

- EX/MEM pipeline register and data-memory access sequencer.
- Captures execute-stage results and drives the registered m3/alu_out/shift_out/pc_p1 that the memory-stage forwarding mux consumes.
- Issues data-memory requests with a req/ack handshake and stalls the upstream pipeline while an access is outstanding.
- Applies branch flushes as bubbles and flags stuck accesses with a timeout.

---
 rtl/ex_mem_pipe.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline register with a req/ack data-memory sequencer.
// Stalls upstream while an access is outstanding and abandons it after TIMEOUT cycles.
`default_nettype none

module ex_mem_pipe #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [1:0]  ex_m3,
  input  logic [15:0] ex_alu_out,
  input  logic [15:0] ex_shift_out,
  input  logic [15:0] ex_pc_p1,
  input  logic [15:0] ex_store_data,
  input  logic [2:0]  ex_rd,
  input  logic        ex_reg_wr,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic        flush,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic [1:0]  m3,
  output logic [15:0] alu_out,
  output logic [15:0] shift_out,
  output logic [15:0] pc_p1,
  output logic [2:0]  mem_rd_dst,
  output logic        mem_reg_wr,
  output logic        mem_valid,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic [15:0] load_data,
  output logic        load_done,
  output logic        stall_up,
  output logic        mem_err
);

  typedef enum logic [0:0] {RUN = 1'b0, WAIT = 1'b1} state_e;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_err_q, mem_err_d;
  logic        pending_flush_q;
  logic [1:0]  m3_q;
  logic [15:0] alu_out_q, shift_out_q, pc_p1_q, wdata_q, load_data_q;
  logic [2:0]  rd_q;
  logic        reg_wr_q, valid_q, mem_rd_q, mem_wr_q, load_done_q;

  logic op, abandon, complete, advance, capture_valid;

  assign op       = valid_q & (mem_rd_q | mem_wr_q);
  assign abandon  = (state_q == WAIT) & (wait_cnt_q == LAST_CNT);
  assign stall_up = op & ~dmem_ack & ~abandon;
  assign complete = op & (dmem_ack | abandon);
  assign advance  = ~stall_up;
  assign capture_valid = ex_valid & ~flush & ~pending_flush_q;

  assign dmem_req   = op & ~abandon;
  assign dmem_we    = valid_q & mem_wr_q;
  assign dmem_addr  = alu_out_q;
  assign dmem_wdata = wdata_q;
  assign m3         = m3_q;
  assign alu_out    = alu_out_q;
  assign shift_out  = shift_out_q;
  assign pc_p1      = pc_p1_q;
  assign mem_rd_dst = rd_q;
  assign mem_reg_wr = reg_wr_q;
  assign mem_valid  = valid_q;
  assign load_data  = load_data_q;
  assign load_done  = load_done_q;
  assign mem_err    = mem_err_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      RUN: begin
        if (op && !dmem_ack) begin
          state_d    = WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      WAIT: begin
        // Ack takes priority over abandon when both land in the same cycle.
        if (dmem_ack || !op) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (abandon) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_data_q <= 16'h0000;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= complete & mem_rd_q;
      if (complete && mem_rd_q) begin
        load_data_q <= dmem_ack ? dmem_rdata : 16'hFFFF;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m3_q            <= 2'b00;
      alu_out_q       <= 16'h0000;
      shift_out_q     <= 16'h0000;
      pc_p1_q         <= 16'h0000;
      wdata_q         <= 16'h0000;
      rd_q            <= 3'b000;
      reg_wr_q        <= 1'b0;
      valid_q         <= 1'b0;
      mem_rd_q        <= 1'b0;
      mem_wr_q        <= 1'b0;
      pending_flush_q <= 1'b0;
    end else if (advance) begin
      m3_q            <= ex_m3;
      alu_out_q       <= ex_alu_out;
      shift_out_q     <= ex_shift_out;
      pc_p1_q         <= ex_pc_p1;
      wdata_q         <= ex_store_data;
      rd_q            <= ex_rd;
      reg_wr_q        <= ex_reg_wr & capture_valid;
      valid_q         <= capture_valid;
      mem_rd_q        <= ex_mem_rd;
      mem_wr_q        <= ex_mem_wr;
      pending_flush_q <= 1'b0;
    end else if (flush) begin
      // Remember a flush that arrives while frozen so the next capture is a bubble.
      pending_flush_q <= 1'b1;
    end
  end

endmodule

`default_nettype wire
